riscv_next_return_stack: RTL and testbench

- Speculative return-address stack (RAS) for the jump predictor, sitting directly upstream of the ID-stage jump/return strategy.
- Pushes the link address of ID-stage calls and pops on ID-stage returns.
- Supplies the predicted return target that the strategy uses as its `ra` data, replacing the architectural register read for `jalr`-via-`ra` prediction.
- Circular buffer: overflow silently discards the oldest entry. Pipeline flush empties the stack.

---
 rtl/riscv_next_pkg.sv | 20 ++
 rtl/riscv_next_return_stack_if.sv | 40 ++++
 rtl/riscv_next_return_stack.sv | 112 +++++++++++
 tb/tb_riscv_next_return_stack.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_next_pkg.sv
// Shared definitions for the jump-prediction front end: RAS defaults and
// the per-cycle stack operation decoded from the ID-stage call/return flags.
package riscv_next_pkg;

    localparam int unsigned RAS_DEPTH_DEFAULT      = 8;
    localparam int unsigned RAS_ADDR_WIDTH_DEFAULT = 64;

    // Encoding matches the {push, pop} bit pair so decode is a plain cast.
    typedef enum logic [1:0] {
        RAS_NONE = 2'b00,
        RAS_POP  = 2'b01,
        RAS_PUSH = 2'b10,
        RAS_SWAP = 2'b11
    } ras_op_e;

    function automatic ras_op_e ras_decode(input logic push, input logic pop);
        return ras_op_e'({push, pop});
    endfunction

endpackage : riscv_next_pkg

// File: rtl/riscv_next_return_stack_if.sv
// ID-stage <-> return-address-stack signal bundle. The ID stage is the master
// (drives call/return/flush), the RAS is the slave (returns the predicted target).
interface riscv_next_return_stack_if #(
    parameter int unsigned ADDR_WIDTH = riscv_next_pkg::RAS_ADDR_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = riscv_next_pkg::RAS_DEPTH_DEFAULT
);
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    logic                   i_push;
    logic [ADDR_WIDTH-1:0]  i_push_addr;
    logic                   i_pop;
    logic                   i_flush;
    logic                   o_top_valid;
    logic [ADDR_WIDTH-1:0]  o_top_addr;
    logic [PTR_WIDTH:0]     o_count;
    logic                   o_overflow;

    modport master (
        output i_push,
        output i_push_addr,
        output i_pop,
        output i_flush,
        input  o_top_valid,
        input  o_top_addr,
        input  o_count,
        input  o_overflow
    );

    modport slave (
        input  i_push,
        input  i_push_addr,
        input  i_pop,
        input  i_flush,
        output o_top_valid,
        output o_top_addr,
        output o_count,
        output o_overflow
    );

endinterface : riscv_next_return_stack_if

// File: rtl/riscv_next_return_stack.sv
// Speculative circular return-address stack: pushes call link addresses,
// pops on returns, and presents the predicted return target with zero latency.
module riscv_next_return_stack
    import riscv_next_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RAS_ADDR_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = RAS_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    riscv_next_return_stack_if.slave  ras
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  tos_q,      tos_d;
    logic [PTR_WIDTH:0]    count_q,    count_d;
    logic                  overflow_q, overflow_d;

    logic                  wr_en;
    logic [PTR_WIDTH-1:0]  wr_idx;
    logic [ADDR_WIDTH-1:0] wr_data;

    ras_op_e               op;
    logic                  empty;
    logic                  full;
    logic [PTR_WIDTH-1:0]  tos_inc;
    logic [PTR_WIDTH-1:0]  tos_dec;

    assign op      = ras_decode(ras.i_push, ras.i_pop);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    // Pointer width equals log2(DEPTH), so natural wrap gives modulo-DEPTH.
    assign tos_inc = tos_q + PTR_ONE;
    assign tos_dec = tos_q - PTR_ONE;

    always_comb begin
        tos_d      = tos_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_idx     = tos_inc;
        wr_data    = ras.i_push_addr;

        if (enable) begin
            overflow_d = 1'b0;
            if (ras.i_flush) begin
                count_d = '0;
            end else begin
                unique case (op)
                    RAS_PUSH: begin
                        tos_d = tos_inc;
                        wr_en = 1'b1;
                        if (full) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end
                    RAS_POP: begin
                        if (!empty) begin
                            tos_d   = tos_dec;
                            count_d = count_q - CNT_ONE;
                        end
                    end
                    RAS_SWAP: begin
                        wr_en = 1'b1;
                        // An empty stack has no top to consume: degrade to a push.
                        if (empty) begin
                            tos_d   = tos_inc;
                            count_d = CNT_ONE;
                        end else begin
                            wr_idx = tos_q;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tos_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            tos_q      <= tos_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign ras.o_top_valid = !empty;
    assign ras.o_top_addr  = empty ? '0 : mem_q[tos_q];
    assign ras.o_count     = count_q;
    assign ras.o_overflow  = overflow_q;

endmodule : riscv_next_return_stack

// File: tb/tb_riscv_next_return_stack.sv
// Directed bench for the return-address stack: reset, LIFO, overflow, swap,
// flush priority, clock enable and reset-under-disable.
module tb_riscv_next_return_stack;

    localparam int unsigned AW = 64;
    localparam int unsigned DP = 8;

    logic clk;
    logic reset;
    logic enable;
    int   checks;
    int   errors;

    riscv_next_return_stack_if #(.ADDR_WIDTH(AW), .DEPTH(DP)) ras_if ();

    riscv_next_return_stack #(.ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .ras    (ras_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic push, input logic [AW-1:0] addr,
                         input logic pop, input logic flush);
        ras_if.i_push      = push;
        ras_if.i_push_addr = addr;
        ras_if.i_pop       = pop;
        ras_if.i_flush     = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (ras_if.o_top_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", ras_if.o_top_valid);
        end
        checks++;
        if (ras_if.o_top_addr !== 64'h0) begin
            errors++; $display("FAIL reset_addr got %h want 0", ras_if.o_top_addr);
        end
        checks++;
        if (ras_if.o_count !== 4'd0 || ras_if.o_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_count got %0d ovf %b want 0 0", ras_if.o_count, ras_if.o_overflow);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        checks++;
        if (ras_if.o_top_valid !== 1'b0 || ras_if.o_top_addr !== 64'h0 || ras_if.o_count !== 4'd0) begin
            errors++;
            $display("FAIL underflow got valid %b addr %h count %0d want 0 0 0",
                     ras_if.o_top_valid, ras_if.o_top_addr, ras_if.o_count);
        end
    endtask

    task automatic test_lifo();
        logic [AW-1:0] pushed [3];
        logic [AW-1:0] want;
        pushed[0] = 64'h1000; pushed[1] = 64'h2000; pushed[2] = 64'h3000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pushed[i], 1'b0, 1'b0);
            tick();
            checks++;
            if (ras_if.o_top_addr !== pushed[i] || ras_if.o_count !== 4'(i + 1)) begin
                errors++;
                $display("FAIL lifo_push%0d got top %h count %0d want %h %0d",
                         i, ras_if.o_top_addr, ras_if.o_count, pushed[i], i + 1);
            end
        end
        for (int i = 2; i >= 0; i--) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
            want = (i > 0) ? pushed[i-1] : 64'h0;
            checks++;
            if (ras_if.o_top_addr !== want || ras_if.o_count !== 4'(i) ||
                ras_if.o_top_valid !== (i > 0)) begin
                errors++;
                $display("FAIL lifo_pop%0d got top %h count %0d valid %b want %h %0d",
                         i, ras_if.o_top_addr, ras_if.o_count, ras_if.o_top_valid, want, i);
            end
        end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] want;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i * 'h100), 1'b0, 1'b0);
            tick();
            checks++;
            if (ras_if.o_overflow !== 1'b0 || ras_if.o_count !== 4'(i)) begin
                errors++;
                $display("FAIL ovf_fill%0d got ovf %b count %0d want 0 %0d",
                         i, ras_if.o_overflow, ras_if.o_count, i);
            end
        end
        drive(1'b1, 64'h900, 1'b0, 1'b0);
        tick();
        checks++;
        if (ras_if.o_overflow !== 1'b1 || ras_if.o_count !== 4'd8 || ras_if.o_top_addr !== 64'h900) begin
            errors++;
            $display("FAIL ovf_ninth got ovf %b count %0d top %h want 1 8 900",
                     ras_if.o_overflow, ras_if.o_count, ras_if.o_top_addr);
        end
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
            want = (k < 8) ? 64'('h900 - k * 'h100) : 64'h0;
            checks++;
            if (ras_if.o_overflow !== 1'b0 || ras_if.o_top_addr !== want ||
                ras_if.o_count !== 4'(8 - k)) begin
                errors++;
                $display("FAIL ovf_pop%0d got ovf %b top %h count %0d want 0 %h %0d",
                         k, ras_if.o_overflow, ras_if.o_top_addr, ras_if.o_count, want, 8 - k);
            end
        end
    endtask

    task automatic test_swap();
        drive(1'b1, 64'hA0, 1'b0, 1'b0); tick();
        drive(1'b1, 64'hB0, 1'b0, 1'b0); tick();
        drive(1'b1, 64'hC0, 1'b1, 1'b0); tick();
        checks++;
        if (ras_if.o_top_addr !== 64'hC0 || ras_if.o_count !== 4'd2) begin
            errors++;
            $display("FAIL swap_top got top %h count %0d want c0 2", ras_if.o_top_addr, ras_if.o_count);
        end
        drive(1'b0, '0, 1'b1, 1'b0); tick();
        checks++;
        if (ras_if.o_top_addr !== 64'hA0 || ras_if.o_count !== 4'd1) begin
            errors++;
            $display("FAIL swap_pop got top %h count %0d want a0 1", ras_if.o_top_addr, ras_if.o_count);
        end
        drive(1'b0, '0, 1'b1, 1'b0); tick();
        drive(1'b1, 64'h55, 1'b1, 1'b0); tick();
        checks++;
        if (ras_if.o_top_addr !== 64'h55 || ras_if.o_count !== 4'd1) begin
            errors++;
            $display("FAIL swap_empty got top %h count %0d want 55 1", ras_if.o_top_addr, ras_if.o_count);
        end
        drive(1'b0, '0, 1'b1, 1'b0); tick();
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 64'(i), 1'b0, 1'b0); tick();
        end
        checks++;
        if (ras_if.o_count !== 4'd3) begin
            errors++; $display("FAIL flush_setup got count %0d want 3", ras_if.o_count);
        end
        drive(1'b1, 64'hDEAD, 1'b0, 1'b1); tick();
        checks++;
        if (ras_if.o_count !== 4'd0 || ras_if.o_top_valid !== 1'b0 || ras_if.o_top_addr !== 64'h0) begin
            errors++;
            $display("FAIL flush_prio got count %0d valid %b top %h want 0 0 0",
                     ras_if.o_count, ras_if.o_top_valid, ras_if.o_top_addr);
        end
        drive(1'b1, 64'hBEEF, 1'b0, 1'b0); tick();
        checks++;
        if (ras_if.o_count !== 4'd1 || ras_if.o_top_addr !== 64'hBEEF) begin
            errors++;
            $display("FAIL flush_push got count %0d top %h want 1 beef", ras_if.o_count, ras_if.o_top_addr);
        end
        drive(1'b0, '0, 1'b1, 1'b0); tick();
        checks++;
        if (ras_if.o_count !== 4'd0 || ras_if.o_top_addr !== 64'h0) begin
            errors++;
            $display("FAIL flush_drain got count %0d top %h want 0 0", ras_if.o_count, ras_if.o_top_addr);
        end
    endtask

    task automatic test_enable_reset();
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 64'(i * 'h10), 1'b0, 1'b0); tick();
        end
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(c[0], 64'hFFFF, c[1], c == 2);
            tick();
            checks++;
            if (ras_if.o_count !== 4'd8 || ras_if.o_top_addr !== 64'h90 || ras_if.o_overflow !== 1'b1) begin
                errors++;
                $display("FAIL enable_hold%0d got count %0d top %h ovf %b want 8 90 1",
                         c, ras_if.o_count, ras_if.o_top_addr, ras_if.o_overflow);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (ras_if.o_count !== 4'd0 || ras_if.o_top_valid !== 1'b0 ||
            ras_if.o_top_addr !== 64'h0 || ras_if.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_disabled got count %0d valid %b top %h ovf %b want 0 0 0 0",
                     ras_if.o_count, ras_if.o_top_valid, ras_if.o_top_addr, ras_if.o_overflow);
        end
        enable = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        enable = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lifo();
        test_overflow();
        test_swap();
        test_flush();
        test_enable_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_riscv_next_return_stack
